// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller and its side-road vehicle detector.
package tlc_pkg;

  typedef enum logic [2:0] {
    RED    = 3'b100,
    YELLOW = 3'b010,
    GREEN  = 3'b001
  } lamp_e;

  localparam int unsigned DEB_CYCLES_DEF    = 4;
  localparam int unsigned DEPART_CYCLES_DEF = 3;

  // Top-level decode of the controller's side-road lamp into side_green.
  function automatic logic is_green(input lamp_e lamp);
    return lamp == GREEN;
  endfunction

endpackage

// File: rtl/tlc_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer; emits the debounced level
// and a single-cycle pulse that is high in the cycle whose edge raises the level.
module tlc_debounce
  import tlc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic deb_o,
  output logic rise_o
);

  localparam int unsigned DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DCW-1:0] DCNT_LAST = DCW'(DEB_CYCLES - 1);

  logic           s1_q, s2_q;
  logic           deb_q, deb_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (s2_q != deb_q) begin
      if (dcnt_q < DCNT_LAST) dcnt_d = dcnt_q + 1'b1;
      else                    deb_d  = s2_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      deb_q  <= 1'b0;
      dcnt_q <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
    end
  end

  // Combinational so the arrival lands on the same edge that flips the level.
  assign rise_o = deb_d & ~deb_q;
  assign deb_o  = deb_q;

endmodule

// File: rtl/tlc_vehicle_detector.sv
// Side-road vehicle detector: debounced loop arrivals feed a saturating queue that is
// drained one vehicle per DEPART_CYCLES of side-road green; sensor flags a non-empty queue.
module tlc_vehicle_detector
  import tlc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int unsigned DEPART_CYCLES = DEPART_CYCLES_DEF,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             raw_loop,
  input  logic             side_green,
  output logic             sensor,
  output logic [CNT_W-1:0] veh_count,
  output logic             overflow
);

  localparam int unsigned DW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [DW-1:0]    DEP_LAST = DW'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             deb_lvl, deb_rise;
  logic             arrival, departure;
  logic [DW-1:0]    dep_q, dep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  tlc_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk_i (clock),
    .rst_i (reset),
    .raw_i (raw_loop),
    .deb_o (deb_lvl),
    .rise_o(deb_rise)
  );

  assign arrival = deb_rise & ~deb_lvl;

  always_comb begin
    dep_d     = '0;
    departure = 1'b0;
    if (side_green && (cnt_q != '0)) begin
      if (dep_q == DEP_LAST) departure = 1'b1;
      else                   dep_d     = dep_q + 1'b1;
    end
  end

  // An arrival coinciding with a departure cancels out, even at saturation.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unique case ({arrival, departure})
      2'b10: begin
        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dep_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      dep_q <= dep_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign sensor    = (cnt_q != '0);
  assign veh_count = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_tlc_vehicle_detector.sv
// Directed bench for tlc_vehicle_detector with default parameters (DEB=4, DEPART=3, CNT_W=4).
module tb_tlc_vehicle_detector;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       raw_loop = 1'b0;
  logic       side_green = 1'b0;
  logic       sensor;
  logic [3:0] veh_count;
  logic       overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  tlc_vehicle_detector #(
    .DEB_CYCLES   (4),
    .DEPART_CYCLES(3),
    .CNT_W        (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .raw_loop  (raw_loop),
    .side_green(side_green),
    .sensor    (sensor),
    .veh_count (veh_count),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] cnt, input logic sen,
                           input logic ovf);
    check({tag, ".count"},    32'(veh_count), 32'(cnt));
    check({tag, ".sensor"},   32'(sensor),    32'(sen));
    check({tag, ".overflow"}, 32'(overflow),  32'(ovf));
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo);
    raw_loop = 1'b1;
    step(hi);
    raw_loop = 1'b0;
    step(lo);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    // Reset held two cycles
    step(2);
    check_all("reset", 4'd0, 1'b0, 1'b0);

    // Clean arrival: count updates exactly 5 edges after the first sampling edge k
    reset    = 1'b0;
    raw_loop = 1'b1;
    step(5);
    check_all("arr_k4", 4'd0, 1'b0, 1'b0);
    step(1);
    check_all("arr_k5", 4'd1, 1'b1, 1'b0);
    step(4);
    raw_loop = 1'b0;
    step(8);
    check_all("arr_hold", 4'd1, 1'b1, 1'b0);

    // Glitch rejection: 3-cycle pulse never counts
    do_reset();
    check_all("rst2", 4'd0, 1'b0, 1'b0);
    raw_loop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("glitch_hi", 32'(veh_count), 32'd0);
    end
    raw_loop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("glitch_lo", 32'(sensor), 32'd0);
    end
    check_all("glitch_end", 4'd0, 1'b0, 1'b0);

    // Three arrivals; the first is a minimum-length 4-cycle pulse
    pulse(4, 8);
    check_all("q1", 4'd1, 1'b1, 1'b0);
    pulse(6, 8);
    check_all("q2", 4'd2, 1'b1, 1'b0);
    pulse(6, 8);
    check_all("q3", 4'd3, 1'b1, 1'b0);

    // Service: one departure every 3 green edges
    side_green = 1'b1;
    step(2);
    check("svc_g2", 32'(veh_count), 32'd3);
    step(1);
    check("svc_g3", 32'(veh_count), 32'd2);
    step(3);
    check("svc_g6", 32'(veh_count), 32'd1);
    step(2);
    check_all("svc_g8", 4'd1, 1'b1, 1'b0);
    step(1);
    check_all("svc_g9", 4'd0, 1'b0, 1'b0);
    step(4);
    check_all("svc_idle", 4'd0, 1'b0, 1'b0);
    side_green = 1'b0;

    // Saturation: 16 arrivals into a 4-bit counter
    for (int i = 0; i < 15; i++) pulse(6, 8);
    check_all("sat15", 4'd15, 1'b1, 1'b0);
    pulse(6, 8);
    check_all("sat16", 4'd15, 1'b1, 1'b1);
    side_green = 1'b1;
    step(3);
    side_green = 1'b0;
    check_all("sat_dep", 4'd14, 1'b1, 1'b1);
    step(5);
    check("sat_sticky", 32'(overflow), 32'd1);

    // Simultaneous arrival and departure
    do_reset();
    check_all("rst3", 4'd0, 1'b0, 1'b0);
    pulse(6, 8);
    pulse(6, 8);
    check("sim_pre", 32'(veh_count), 32'd2);
    raw_loop = 1'b1;
    step(3);
    side_green = 1'b1;
    step(2);
    check("sim_k4", 32'(veh_count), 32'd2);
    step(1);
    check("sim_k5", 32'(veh_count), 32'd2);
    step(2);
    check("sim_k7", 32'(veh_count), 32'd2);
    step(1);
    check_all("sim_k8", 4'd1, 1'b1, 1'b0);
    raw_loop   = 1'b0;
    side_green = 1'b0;
    step(8);

    // Reset mid-operation with raw_loop held high
    pulse(6, 8);
    raw_loop = 1'b1;
    step(6);
    check("mid_q3", 32'(veh_count), 32'd3);
    do_reset();
    check_all("mid_rst", 4'd0, 1'b0, 1'b0);
    step(5);
    check_all("mid_k4", 4'd0, 1'b0, 1'b0);
    step(1);
    check_all("mid_k5", 4'd1, 1'b1, 1'b0);
    raw_loop = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlc_vehicle_detector.md
Name: tlc_vehicle_detector

Overview:
- Conditions the side-road inductive-loop input into the clean `sensor` level that the traffic-light controller I_TLC consumes. Sits directly upstream of I_TLC.
- Functions:
  - synchronises the asynchronous loop signal;
  - debounces it;
  - counts waiting vehicles;
  - retires vehicles while the side road shows green.
- `sensor` stays high while any vehicle is waiting, so a short loop pulse is never lost.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles required before the debounced level changes (must be at least 1).
- DEPART_CYCLES, 3: continuous side-green cycles that retire one queued vehicle (must be at least 1).
- CNT_W, 4: width of the vehicle queue counter; saturates at 2^CNT_W-1.

Ports:
- clock, input, 1: single system clock, rising edge.
- reset, input, 1: synchronous, active-high; clears all state on the clock edge where it is sampled high.
- raw_loop, input, 1: loop-detector level, asynchronous to clock, may bounce.
- side_green, input, 1: high while the side-road lamp is GREEN; the top level decodes it from the controller's S output using the package encoding.
- sensor, output, 1: vehicle-waiting flag, drives I_TLC sensor.
- veh_count, output, CNT_W: current queue depth.
- overflow, output, 1: sticky flag, set when an arrival is dropped at saturation.

Behaviour:
- Reset (synchronous, active-high) clears every register: sync flops, debounce state, debounce counter, depart timer, veh_count, overflow. All outputs are 0 on the cycle after reset is sampled.
- Synchroniser: two flops, raw_loop -> s1 -> s2. The edge on which raw_loop is first sampled high is edge k; s2 goes high at edge k+1.
- Debounce (registers deb and dcnt):
  - On each edge, if s2 == deb then dcnt is cleared.
  - Else if dcnt < DEB_CYCLES-1 then dcnt increments.
  - Else deb <= s2 and dcnt is cleared.
  - Net effect: deb changes after DEB_CYCLES consecutive mismatched edges, at edge k+1+DEB_CYCLES.
  - Pulses shorter than that are rejected.
- Arrival:
  - An arrival occurs on the edge where deb flips 0 -> 1.
  - A 1 -> 0 flip is not an event.
  - Default latency: raw_loop rise to veh_count and sensor update is 5 edges after the sampling edge k.
- Departure timer (dep_t):
  - Counts edges where side_green is 1 and veh_count is nonzero.
  - When dep_t reaches DEPART_CYCLES-1, a departure occurs and dep_t is cleared.
  - dep_t is cleared whenever side_green is 0 or veh_count is 0.
- Queue update, per edge:
  - Arrival only: increment, unless at max; at max the count holds and overflow is set.
  - Departure only: decrement (never below 0).
  - Both on the same edge: count unchanged, overflow not set, dep_t cleared.
  - Neither: hold.
- sensor = (veh_count != 0), driven from the registered count; no combinational path from raw_loop.
- overflow is cleared only by reset.
- Reset mid-operation discards the queue.
  - If raw_loop is still high after reset is released, deb restarts at 0, so the vehicle is recounted as a new arrival after the normal latency.
- side_green dropping mid-interval discards the partial departure interval.

Decomposition:
- Shared package tlc_pkg holds:
  - lamp encodings: RED=3'b100, YELLOW=3'b010, GREEN=3'b001, also used by I_TLC and the top-level side_green decode;
  - default constants DEB_CYCLES_DEF and DEPART_CYCLES_DEF.
- One sub-module, tlc_debounce: synchroniser plus debounce, parameterised by DEB_CYCLES, output deb and a one-cycle rise pulse. The queue and departure logic stay in the parent.

Test Plan:
- Clean arrival (defaults): assert reset 2 cycles, release, raw_loop=1 held for 10 cycles, side_green=0 -> veh_count goes 0 -> 1 and sensor rises exactly 5 edges after the first sampling edge; the count stays at 1 afterwards.
- Glitch rejection: raw_loop high for 3 cycles, then low -> deb never rises; veh_count=0 and sensor=0 throughout.
- Three arrivals, then service: three debounced pulses with side_green=0 give veh_count=3. Then hold side_green=1 -> count reads 2, 1, 0 at 3-cycle intervals; sensor falls on the edge the count reaches 0.
- Saturation: 16 arrivals with CNT_W=4 and side_green=0 -> veh_count=15 and overflow=1 after the 16th; overflow stays 1 after later departures until reset.
- Simultaneous events: with veh_count=2 and side_green=1, align a debounced arrival with the departure edge -> veh_count stays 2; the next departure occurs DEPART_CYCLES edges later.
- Reset mid-operation: veh_count=3 with raw_loop held high, assert reset 1 cycle -> all outputs 0 on the next edge; after release a new arrival is counted 5 edges later, giving veh_count=1.
